ins_cache: RTL and testbench
============================

INS_CACHE -- requirements
Module: ins_cache

Interface
REQ-001 Parameter LINE_NUM, default 32, number of direct-mapped lines; power of two, 2..256.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-004 rdy  input  1  global ready; low freezes the FSM except fill-completion capture (REQ-014).
REQ-005 clear  input  1  pipeline flush from branch mispredict.
REQ-006 fetch_req  input  1  fetch unit requests instruction at fetch_pc.
REQ-007 fetch_pc  input  32  instruction address, 4-byte aligned.
REQ-008 fetch_hit  output  1  fetch_ins valid for fetch_pc this cycle.
REQ-009 fetch_ins  output  32  instruction word.
REQ-010 ins_fetch_sig  output  1  fill request to memory controller.
REQ-011 ins_addr  output  32  fill base address, 8-byte aligned.
REQ-012 ins_fetch_done  input  1  one-cycle pulse: ins_data holds 8 bytes, byte k at ins_addr+k in bits [8k+7:8k].
REQ-013 ins_data  input  64  fill line data.

Function
REQ-014 Line = 8 bytes; offset pc[2:0], index pc[3+IDX-1:3], tag pc[31:3+IDX], IDX=log2(LINE_NUM); per line: valid bit, tag, 64-bit data, all in flops.
REQ-015 fetch_hit combinational: fetch_req & valid[idx] & tag match & !clear & rdy; fetch_ins = line[31:0] if pc[2]=0 else line[63:32]; fetch_ins = 0 when not hit.
REQ-016 FSM states IDLE, FILL, WAIT1.
REQ-017 IDLE: fetch_req & miss & rdy & !clear -> FILL next cycle; latch ins_addr = {fetch_pc[31:3],3'b000}, latch index/tag; assert ins_fetch_sig.
REQ-018 FILL: ins_fetch_sig and ins_addr held stable; no other fill issued; hits on other lines still served per REQ-015.
REQ-019 FILL & ins_fetch_done (captured even when rdy low): write data/tag, set valid, deassert ins_fetch_sig same edge, -> WAIT1.
REQ-020 WAIT1: one idle cycle (controller ignores requests the cycle after done) -> IDLE; no new fill issued in WAIT1.
REQ-021 FILL & clear & !ins_fetch_done -> IDLE, ins_fetch_sig deasserted, no line written.
REQ-022 FILL & clear & ins_fetch_done same cycle: line written (data is address-correct), -> WAIT1; fetch_hit stays 0 that cycle.
REQ-023 Hit latency 0 cycles; miss latency = controller fill time + 2 cycles (write, WAIT1 ... hit available the cycle after write).
REQ-024 Fill to index already valid overwrites (no replacement choice); fill for same line as hit target replaces atomically at the edge.
REQ-025 No write path; self-modifying code unsupported; no invalidate input.

Reset
REQ-026 On rst: all valid bits 0, state IDLE, ins_fetch_sig 0, ins_addr 0; fetch_hit 0, fetch_ins 0 follow combinationally.
REQ-027 Reset mid-FILL aborts fill; pulse of ins_fetch_done arriving after reset is ignored (state IDLE).
REQ-028 Tag/data arrays need no reset.

Structure
REQ-029 Shared package holds LINE_BYTES=8, state encodings (IDLE/FILL/WAIT1), fetch address field widths.
REQ-030 One sub-module natural: icache_line_store (valid/tag/data flops, combinational read port, single write port).

Verification
REQ-031 Cold miss: reset, fetch_req pc=0x0000_0004 -> ins_fetch_sig=1, ins_addr=0x0; done with ins_data=0x1111_2222_3333_4444 -> 2 cycles later fetch_hit=1, fetch_ins=0x1111_2222.
REQ-032 Hit same line: after REQ-031, pc=0x0000_0000 -> fetch_hit=1 same cycle, fetch_ins=0x3333_4444, ins_fetch_sig stays 0.
REQ-033 Conflict: LINE_NUM=32, fill pc=0x0, then pc=0x100 -> miss, fill ins_addr=0x100 overwrites index 0; pc=0x0 then misses.
REQ-034 Clear abort: miss pc=0x40, clear pulsed 3 cycles into FILL before done -> ins_fetch_sig 0 next cycle, valid[8] stays 0.
REQ-035 Simultaneous clear+done: pc=0x80 fill, clear and ins_fetch_done same cycle -> line 16 valid, fetch_hit 0 that cycle, hit on pc=0x80 two cycles later.
REQ-036 rdy low on done cycle: done captured, line written; reset asserted mid-FILL -> ins_fetch_sig 0 immediately, late done ignored.

Source files
------------

// File: rtl/ins_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
// Line geometry, fetch address field widths and fill FSM encodings.
package ins_cache_pkg;

  localparam int LINE_BYTES = 8;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int OFF_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WAIT1 = 2'd2
  } state_e;

  function automatic int tag_width(input int idx_w);
    return ADDR_W - OFF_W - idx_w;
  endfunction

endpackage

// File: rtl/ins_cache_line_store.sv
// Valid/tag/data flops for all cache lines.
// One combinational read port, one synchronous write port.
module icache_line_store
  import ins_cache_pkg::*;
#(
  parameter int LINE_NUM = 32,
  parameter int IDX_W    = $clog2(LINE_NUM),
  parameter int TAG_W    = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic              rd_valid_o,
  output logic [TAG_W-1:0]  rd_tag_o,
  output logic [LINE_W-1:0] rd_data_o,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [LINE_W-1:0] wr_data_i
);

  logic [LINE_NUM-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [LINE_W-1:0]   data_q [LINE_NUM];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag and data are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/ins_cache.sv
// Direct-mapped instruction cache, 8-byte lines, zero-latency hits.
// Misses issue one line fill to the memory controller at a time.
module ins_cache
  import ins_cache_pkg::*;
#(
  parameter int LINE_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_hit,
  output logic [WORD_W-1:0] fetch_ins,
  output logic              ins_fetch_sig,
  output logic [ADDR_W-1:0] ins_addr,
  input  logic              ins_fetch_done,
  input  logic [LINE_W-1:0] ins_data
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = tag_width(IDX_W);
  localparam int TAG_LO = OFF_W + IDX_W;

  state_e            state_q;
  logic              sig_q;
  logic [ADDR_W-1:0] addr_q;

  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  pc_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              hit_raw;
  logic              miss;
  logic              we;
  logic [1:0]        unused_pc;

  assign pc_idx    = fetch_pc[TAG_LO-1:OFF_W];
  assign pc_tag    = fetch_pc[ADDR_W-1:TAG_LO];
  assign unused_pc = fetch_pc[1:0];

  assign hit_raw   = rd_valid & (rd_tag == pc_tag);
  assign fetch_hit = fetch_req & hit_raw & ~clear & rdy;
  assign miss      = fetch_req & ~hit_raw & rdy & ~clear;

  always_comb begin
    fetch_ins = '0;
    if (fetch_hit) begin
      fetch_ins = fetch_pc[2] ? rd_data[63:32] : rd_data[31:0];
    end
  end

  // A returning fill lands even under clear or a stalled pipeline.
  assign we = (state_q == FILL) & ins_fetch_done;

  icache_line_store #(
    .LINE_NUM (LINE_NUM),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pc_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (we),
    .wr_idx_i   (addr_q[TAG_LO-1:OFF_W]),
    .wr_tag_i   (addr_q[ADDR_W-1:TAG_LO]),
    .wr_data_i  (ins_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= 1'b0;
      addr_q  <= '0;
    end else if (we) begin
      state_q <= WAIT1;
      sig_q   <= 1'b0;
    end else if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            state_q <= FILL;
            sig_q   <= 1'b1;
            addr_q  <= {fetch_pc[ADDR_W-1:OFF_W], 3'b000};
          end
        end
        FILL: begin
          if (clear) begin
            state_q <= IDLE;
            sig_q   <= 1'b0;
          end
        end
        WAIT1: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          sig_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ins_fetch_sig = sig_q;
  assign ins_addr      = addr_q;

endmodule

// File: tb/tb_ins_cache.sv
// Directed self-checking bench for ins_cache (LINE_NUM = 32).
// Table-driven hit/miss vectors plus hand-written fill sequences.
module tb_ins_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_hit;
  logic [31:0] fetch_ins;
  logic        ins_fetch_sig;
  logic [31:0] ins_addr;
  logic        ins_fetch_done;
  logic [63:0] ins_data;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D2 = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D5 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D6 = 64'hDEAD_BEEF_CAFE_F00D;

  ins_cache #(.LINE_NUM(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .fetch_hit      (fetch_hit),
    .fetch_ins      (fetch_ins),
    .ins_fetch_sig  (ins_fetch_sig),
    .ins_addr       (ins_addr),
    .ins_fetch_done (ins_fetch_done),
    .ins_data       (ins_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        clr;
    logic        rdy;
    logic        hit;
    logic [31:0] ins;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Miss in IDLE, one cycle in FILL, done pulse, then WAIT1 -> IDLE.
  task automatic do_fill(input logic [31:0] a, input logic [63:0] d,
                         input string nm);
    fetch_req = 1'b1;
    fetch_pc  = a;
    step();
    fetch_req = 1'b0;
    sample();
    chk({nm, " sig"}, 64'(ins_fetch_sig), 64'd1);
    chk({nm, " addr"}, 64'(ins_addr), 64'({a[31:3], 3'b000}));
    ins_fetch_done = 1'b1;
    ins_data       = d;
    step();
    ins_fetch_done = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'hCCCC_DDDD};
    vecs[1] = '{1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 32'hAAAA_BBBB};
    vecs[2] = '{1'b1, 32'h018, 1'b0, 1'b1, 1'b1, 32'h7777_8888};
    vecs[3] = '{1'b1, 32'h01C, 1'b0, 1'b1, 1'b1, 32'h5555_6666};
    vecs[4] = '{1'b0, 32'h018, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h018, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h000, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{1'b1, 32'h418, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[9] = '{1'b1, 32'h020, 1'b1, 1'b1, 1'b0, 32'h0};

    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'h4;
    ins_fetch_done = 1'b0; ins_data = '0;

    sample();
    chk("rst sig", 64'(ins_fetch_sig), 64'd0);
    chk("rst addr", 64'(ins_addr), 64'd0);
    chk("rst hit", 64'(fetch_hit), 64'd0);
    chk("rst ins", 64'(fetch_ins), 64'd0);
    step();
    rst = 1'b0;

    // Cold miss at pc 0x4
    sample();
    chk("cold miss hit", 64'(fetch_hit), 64'd0);
    step();
    fetch_req = 1'b0;
    sample();
    chk("cold sig", 64'(ins_fetch_sig), 64'd1);
    chk("cold addr", 64'(ins_addr), 64'h0);
    step();
    step();
    sample();
    chk("cold sig held", 64'(ins_fetch_sig), 64'd1);
    chk("cold addr held", 64'(ins_addr), 64'h0);
    ins_fetch_done = 1'b1;
    ins_data       = D1;
    step();
    ins_fetch_done = 1'b0;
    ins_data       = '0;
    sample();
    chk("cold sig drop", 64'(ins_fetch_sig), 64'd0);
    step();
    fetch_req = 1'b1;
    fetch_pc  = 32'h4;
    sample();
    chk("cold hit", 64'(fetch_hit), 64'd1);
    chk("cold ins hi", 64'(fetch_ins), 64'h1111_2222);
    fetch_pc = 32'h0;
    #1;
    chk("same line hit", 64'(fetch_hit), 64'd1);
    chk("same line ins lo", 64'(fetch_ins), 64'h3333_4444);
    step();
    sample();
    chk("hit no fill", 64'(ins_fetch_sig), 64'd0);

    // Conflict on index 0
    do_fill(32'h100, D2, "conflict");
    fetch_req = 1'b1;
    fetch_pc  = 32'h100;
    sample();
    chk("conflict hit", 64'(fetch_hit), 64'd1);
    chk("conflict ins", 64'(fetch_ins), 64'hCCCC_DDDD);
    fetch_pc = 32'h0;
    #1;
    chk("evicted miss", 64'(fetch_hit), 64'd0);
    step();
    fetch_req = 1'b0;
    sample();
    chk("evicted refill sig", 64'(ins_fetch_sig), 64'd1);
    chk("evicted refill addr", 64'(ins_addr), 64'h0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    sample();
    chk("refill abort", 64'(ins_fetch_sig), 64'd0);

    do_fill(32'h18, D3, "idx3");

    for (int i = 0; i < 10; i++) begin
      fetch_req = vecs[i].req;
      fetch_pc  = vecs[i].pc;
      clear     = vecs[i].clr;
      rdy       = vecs[i].rdy;
      sample();
      chk($sformatf("vec%0d hit", i), 64'(fetch_hit), 64'(vecs[i].hit));
      chk($sformatf("vec%0d ins", i), 64'(fetch_ins), 64'(vecs[i].ins));
      step();
    end
    fetch_req = 1'b0; clear = 1'b0; rdy = 1'b1;
    sample();
    chk("table no fill", 64'(ins_fetch_sig), 64'd0);

    // Clear abort of pc 0x40 fill
    fetch_req = 1'b1;
    fetch_pc  = 32'h40;
    step();
    fetch_pc = 32'h100;
    sample();
    chk("abort sig", 64'(ins_fetch_sig), 64'd1);
    chk("abort addr", 64'(ins_addr), 64'h40);
    chk("hit during fill", 64'(fetch_hit), 64'd1);
    chk("hit during fill ins", 64'(fetch_ins), 64'hCCCC_DDDD);
    step();
    step();
    fetch_req = 1'b0;
    clear     = 1'b1;
    step();
    clear = 1'b0;
    sample();
    chk("abort sig drop", 64'(ins_fetch_sig), 64'd0);
    ins_fetch_done = 1'b1;
    ins_data       = D6;
    step();
    ins_fetch_done = 1'b0;
    fetch_req      = 1'b1;
    fetch_pc       = 32'h40;
    sample();
    chk("abort no write", 64'(fetch_hit), 64'd0);
    step();
    fetch_req = 1'b0;
    sample();
    chk("abort refill sig", 64'(ins_fetch_sig), 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;

    // clear and done together on pc 0x80
    fetch_req = 1'b1;
    fetch_pc  = 32'h80;
    step();
    sample();
    chk("simul sig", 64'(ins_fetch_sig), 64'd1);
    chk("simul addr", 64'(ins_addr), 64'h80);
    ins_fetch_done = 1'b1;
    clear          = 1'b1;
    ins_data       = D4;
    #1;
    chk("simul hit gated", 64'(fetch_hit), 64'd0);
    step();
    ins_fetch_done = 1'b0;
    clear          = 1'b0;
    fetch_req      = 1'b0;
    sample();
    chk("simul sig drop", 64'(ins_fetch_sig), 64'd0);
    step();
    fetch_req = 1'b1;
    fetch_pc  = 32'h84;
    sample();
    chk("simul hit", 64'(fetch_hit), 64'd1);
    chk("simul ins", 64'(fetch_ins), 64'h0123_4567);
    step();

    // Done while rdy low
    fetch_req = 1'b1;
    fetch_pc  = 32'hC0;
    step();
    fetch_req      = 1'b0;
    rdy            = 1'b0;
    ins_fetch_done = 1'b1;
    ins_data       = D5;
    step();
    ins_fetch_done = 1'b0;
    sample();
    chk("rdy low done sig", 64'(ins_fetch_sig), 64'd0);
    rdy = 1'b1;
    step();
    fetch_req = 1'b1;
    fetch_pc  = 32'hC0;
    sample();
    chk("rdy low hit", 64'(fetch_hit), 64'd1);
    chk("rdy low ins", 64'(fetch_ins), 64'h7654_3210);
    step();

    // Reset mid-fill, late done ignored
    fetch_req = 1'b1;
    fetch_pc  = 32'hE0;
    step();
    fetch_req = 1'b0;
    sample();
    chk("pre rst sig", 64'(ins_fetch_sig), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid rst sig", 64'(ins_fetch_sig), 64'd0);
    chk("mid rst addr", 64'(ins_addr), 64'h0);
    step();
    rst            = 1'b0;
    ins_fetch_done = 1'b1;
    ins_data       = D6;
    step();
    ins_fetch_done = 1'b0;
    sample();
    chk("late done sig", 64'(ins_fetch_sig), 64'd0);
    fetch_req = 1'b1;
    fetch_pc  = 32'hE0;
    #1;
    chk("late done no write", 64'(fetch_hit), 64'd0);
    fetch_pc = 32'h100;
    #1;
    chk("rst cleared valid", 64'(fetch_hit), 64'd0);
    fetch_req = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
